jtframe_sdram_sched: RTL and testbench

- Scheduler in front of the single-command SDRAM engine; shares it between the ROM-load port (prog) and four game bank ports (ba0 R/W; ba1–ba3 read-only).
- Inserts auto-refresh commands: opportunistically while the game allows it, forced when refresh debt grows.
- Keeps exactly one command outstanding at the engine.
- Returns per-port ack (command accepted) and rdy (data/write complete) pulses.

---
 rtl/jtframe_sdram_sched.sv | 200 ++++++++++++++++++++
 tb/tb_jtframe_sdram_sched.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_sdram_sched.sv
// Shares one SDRAM command engine between prog, four bank ports and auto-refresh; JTFRAME_SDRAM_FIXPRIO_EN = fixed bank priority.
// Request seen in IDLE -> cmd_req next cycle; cmd_* held until cmd_ack, one command outstanding until cmd_done.
module jtframe_sdram_sched #(
  parameter int SDRAMW       = 23,
  parameter int RFSH_PERIOD  = 374,
  parameter int RFSH_MAXDEBT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              downloading,
  input  logic [SDRAMW-1:0] prog_addr,
  input  logic              prog_rd,
  input  logic              prog_we,
  output logic              prog_ack,
  output logic              prog_rdy,
  input  logic [SDRAMW-1:0] ba0_addr,
  input  logic              ba0_rd,
  input  logic              ba0_wr,
  input  logic [SDRAMW-1:0] ba1_addr,
  input  logic              ba1_rd,
  input  logic [SDRAMW-1:0] ba2_addr,
  input  logic              ba2_rd,
  input  logic [SDRAMW-1:0] ba3_addr,
  input  logic              ba3_rd,
  output logic [3:0]        ba_ack,
  output logic [3:0]        ba_rdy,
  input  logic              rfsh_en,
  output logic              cmd_req,
  output logic [1:0]        cmd_ba,
  output logic [SDRAMW-1:0] cmd_addr,
  output logic              cmd_wr,
  output logic              cmd_rfsh,
  input  logic              cmd_ack,
  input  logic              cmd_done
);

  localparam int CW = $clog2(RFSH_PERIOD + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  typedef struct packed {
    logic              rfsh;
    logic              prog;
    logic [1:0]        ba;
    logic              wr;
    logic [SDRAMW-1:0] addr;
  } cmd_t;

  state_t            state;
  cmd_t              cur;
  cmd_t              sel;
  logic              sel_vld;
  logic [CW-1:0]     rfsh_cnt;
  logic [1:0]        debt;
  logic [1:0]        ptr;
  logic [1:0]        rr_ba;
  logic [1:0]        idx;
  logic              rr_hit;
  logic [3:0]        ba_req;
  logic [SDRAMW-1:0] rr_addr;
  logic              rfsh_wrap;
  logic              rfsh_done;
  logic              force_rfsh;
  logic              rdy_pend;

  assign cmd_ba   = cur.ba;
  assign cmd_addr = cur.addr;
  assign cmd_wr   = cur.wr;
  assign cmd_rfsh = cur.rfsh;

  assign ba_req     = {ba3_rd, ba2_rd, ba1_rd, ba0_rd | ba0_wr};
  assign force_rfsh = debt >= 2'(RFSH_MAXDEBT);
  assign rfsh_wrap  = rfsh_cnt == CW'(RFSH_PERIOD - 1);
  assign rfsh_done  = cur.rfsh & cmd_done &
                      ((state == WAIT) | ((state == ISSUE) & cmd_ack));

  // Walk from the farthest offset back to the pointer so the closest request wins.
  always_comb begin
    rr_hit = 1'b0;
    rr_ba  = ptr;
    idx    = ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (ba_req[idx]) begin
        rr_hit = 1'b1;
        rr_ba  = idx;
      end
    end
  end

  always_comb begin
    case (rr_ba)
      2'd0:    rr_addr = ba0_addr;
      2'd1:    rr_addr = ba1_addr;
      2'd2:    rr_addr = ba2_addr;
      default: rr_addr = ba3_addr;
    endcase
  end

  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    if (force_rfsh) begin
      sel_vld  = 1'b1;
      sel.rfsh = 1'b1;
    end else if (downloading) begin
      if (prog_rd | prog_we) begin
        sel_vld  = 1'b1;
        sel.prog = 1'b1;
        sel.wr   = prog_we;
        sel.addr = prog_addr;
      end
    end else if (rr_hit) begin
      sel_vld  = 1'b1;
      sel.ba   = rr_ba;
      sel.wr   = (rr_ba == 2'd0) & ba0_wr;
      sel.addr = rr_addr;
    end else if (debt != 2'd0 && rfsh_en) begin
      sel_vld  = 1'b1;
      sel.rfsh = 1'b1;
    end
  end

  function automatic logic [3:0] bank_bit(input cmd_t c);
    return (c.rfsh | c.prog) ? 4'b0000 : (4'b0001 << c.ba);
  endfunction

  // A refresh finishing on the same cycle as a new credit leaves the debt as is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rfsh_cnt <= '0;
      debt     <= 2'd0;
    end else begin
      rfsh_cnt <= rfsh_wrap ? '0 : rfsh_cnt + CW'(1);
      if (rfsh_wrap && !rfsh_done && debt != 2'd3)
        debt <= debt + 2'd1;
      else if (!rfsh_wrap && rfsh_done && debt != 2'd0)
        debt <= debt - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cur      <= '0;
      cmd_req  <= 1'b0;
      ptr      <= 2'd0;
      prog_ack <= 1'b0;
      prog_rdy <= 1'b0;
      ba_ack   <= 4'b0000;
      ba_rdy   <= 4'b0000;
      rdy_pend <= 1'b0;
    end else begin
      prog_ack <= 1'b0;
      prog_rdy <= 1'b0;
      ba_ack   <= 4'b0000;
      ba_rdy   <= 4'b0000;
      rdy_pend <= 1'b0;
      // Deferred completion of an ack+done cycle, so rdy lands one cycle after ack.
      if (rdy_pend) begin
        prog_rdy <= cur.prog;
        ba_rdy   <= bank_bit(cur);
      end
      case (state)
        IDLE: begin
          if (sel_vld) begin
            cur     <= sel;
            cmd_req <= 1'b1;
            state   <= ISSUE;
`ifndef JTFRAME_SDRAM_FIXPRIO_EN
            if (!sel.rfsh && !sel.prog) ptr <= sel.ba + 2'd1;
`endif
          end
        end
        ISSUE: begin
          if (cmd_ack) begin
            cmd_req  <= 1'b0;
            prog_ack <= cur.prog;
            ba_ack   <= bank_bit(cur);
            if (cmd_done) begin
              rdy_pend <= 1'b1;
              state    <= IDLE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cmd_done) begin
            prog_rdy <= cur.prog;
            ba_rdy   <= bank_bit(cur);
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_sdram_sched.sv
// Scoreboarded bench for jtframe_sdram_sched with a behavioural engine of programmable ack/done delay.
module tb_jtframe_sdram_sched;

  localparam int AW = 23;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          downloading, prog_rd, prog_we, rfsh_en;
  logic [AW-1:0] prog_addr, ba0_addr, ba1_addr, ba2_addr, ba3_addr;
  logic          ba0_rd, ba0_wr, ba1_rd, ba2_rd, ba3_rd;
  logic          cmd_ack, cmd_done;
  logic          prog_ack, prog_rdy, cmd_req, cmd_wr, cmd_rfsh;
  logic [3:0]    ba_ack, ba_rdy;
  logic [1:0]    cmd_ba;
  logic [AW-1:0] cmd_addr;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ack_dly = 2;
  int done_dly = 4;
  int n_ba_ack = 0;
  int n_prog_ack = 0;
  int n_prog_rdy = 0;
  int ack_cyc[4];
  int rdy_cyc[4];
  int exp_ack[$];
  int exp_rdy[$];
  logic [3:0] prev_ack = 4'b0000;

  jtframe_sdram_sched #(.SDRAMW(AW), .RFSH_PERIOD(16), .RFSH_MAXDEBT(2)) dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .prog_addr(prog_addr), .prog_rd(prog_rd), .prog_we(prog_we),
    .prog_ack(prog_ack), .prog_rdy(prog_rdy),
    .ba0_addr(ba0_addr), .ba0_rd(ba0_rd), .ba0_wr(ba0_wr),
    .ba1_addr(ba1_addr), .ba1_rd(ba1_rd),
    .ba2_addr(ba2_addr), .ba2_rd(ba2_rd),
    .ba3_addr(ba3_addr), .ba3_rd(ba3_rd),
    .ba_ack(ba_ack), .ba_rdy(ba_rdy), .rfsh_en(rfsh_en),
    .cmd_req(cmd_req), .cmd_ba(cmd_ba), .cmd_addr(cmd_addr),
    .cmd_wr(cmd_wr), .cmd_rfsh(cmd_rfsh),
    .cmd_ack(cmd_ack), .cmd_done(cmd_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, want 'h%0h", tag, got, exp);
    end
  endtask

  // Engine: answers each new cmd_req after ack_dly cycles, completes after done_dly.
  initial begin
    cmd_ack  = 1'b0;
    cmd_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (cmd_req && !rst) begin
        for (int i = 0; i < ack_dly; i++) begin @(posedge clk); #1; end
        cmd_ack  = 1'b1;
        cmd_done = (done_dly == ack_dly);
        @(posedge clk); #1;
        cmd_ack  = 1'b0;
        cmd_done = 1'b0;
        if (done_dly > ack_dly) begin
          for (int i = ack_dly + 1; i < done_dly; i++) begin @(posedge clk); #1; end
          cmd_done = 1'b1;
          @(posedge clk); #1;
          cmd_done = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    int e;
    if (!rst) begin
      if (ba_ack != 4'b0000) begin
        n_ba_ack++;
        if (exp_ack.size() == 0) chk("ba_ack_unexpected", ba_ack, 0);
        else begin
          e = exp_ack.pop_front();
          chk("ba_ack_order", ba_ack, 32'(4'b0001 << e));
        end
        chk("ba_ack_1cyc", ba_ack & prev_ack, 0);
        for (int b = 0; b < 4; b++) if (ba_ack[b]) ack_cyc[b] = cyc;
      end
      if (ba_rdy != 4'b0000) begin
        if (exp_rdy.size() == 0) chk("ba_rdy_unexpected", ba_rdy, 0);
        else begin
          e = exp_rdy.pop_front();
          chk("ba_rdy_order", ba_rdy, 32'(4'b0001 << e));
        end
        for (int b = 0; b < 4; b++) if (ba_rdy[b]) rdy_cyc[b] = cyc;
      end
      if (prog_ack) n_prog_ack++;
      if (prog_rdy) n_prog_rdy++;
    end
    prev_ack = ba_ack;
  end

  task automatic push_exp(input int b);
    exp_ack.push_back(b);
    exp_rdy.push_back(b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    chk("rst_ctrl_outs", {prog_ack, prog_rdy, ba_ack, ba_rdy, cmd_req, cmd_ba, cmd_wr, cmd_rfsh}, 0);
    chk("rst_cmd_addr", cmd_addr, 0);
    rst = 1'b0;
  endtask

  task automatic wait_cmd(input int budget, output int n);
    logic prev;
    bit hit;
    prev = cmd_req;
    hit  = 1'b0;
    n    = 0;
    while (!hit && n < budget) begin
      @(posedge clk); #1;
      n++;
      hit  = cmd_req && !prev;
      prev = cmd_req;
    end
    if (!hit) chk("cmd_timeout", n, 0);
  endtask

  task automatic wait_ack(input int b, input int budget);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ba_ack[b] && n < budget);
    if (!ba_ack[b]) chk("ack_timeout", n, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    int fp_seq[4];
    downloading = 0; prog_rd = 0; prog_we = 0; rfsh_en = 0;
    prog_addr = '0; ba0_addr = 23'h000abc; ba1_addr = 23'h011111;
    ba2_addr = 23'h022222; ba3_addr = 23'h033333;
    ba0_rd = 0; ba0_wr = 0; ba1_rd = 0; ba2_rd = 0; ba3_rd = 0;

    // Reset with all banks requesting, then round-robin 0,1,2,3,0
    ba0_rd = 1; ba1_rd = 1; ba2_rd = 1; ba3_rd = 1;
    push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
    do_reset();
    wait_cmd(8, n);
    chk("rst_req_latency", n, 1);
    chk("rst_grant_ba", cmd_ba, 0);
    chk("rst_grant_addr", cmd_addr, 23'h000abc);
    chk("rst_grant_rfsh", cmd_rfsh, 0);
    wait_ack(0, 60); wait_ack(1, 60); wait_ack(2, 60); wait_ack(3, 60); wait_ack(0, 60);
    ba0_rd = 0; ba1_rd = 0; ba2_rd = 0; ba3_rd = 0;
    repeat (10) @(posedge clk);
    #1;

    // Forced refresh with rfsh_en low: debt reaches 2 on the second wrap
    rfsh_en = 0;
    do_reset();
    wait_cmd(60, n);
    chk("rfsh_forced_cycle", n, 33);
    chk("rfsh_forced_flag", cmd_rfsh, 1);

    // Opportunistic refresh after the first wrap, then the debt must be repaid
    rfsh_en = 1;
    do_reset();
    wait_cmd(60, n);
    chk("rfsh_opp_cycle", n, 17);
    chk("rfsh_opp_flag", cmd_rfsh, 1);
    wait_cmd(60, n);
    chk("rfsh_debt_repaid", n, 16);
    rfsh_en = 0;

    // Download mode: only prog is served
    downloading = 1; prog_we = 1; prog_addr = 23'h02a5a5; ba1_rd = 1;
    do_reset();
    wait_cmd(8, n);
    chk("dl_req_latency", n, 1);
    chk("dl_cmd_wr", cmd_wr, 1);
    chk("dl_cmd_ba", cmd_ba, 0);
    chk("dl_cmd_addr", cmd_addr, 23'h02a5a5);
    chk("dl_cmd_rfsh", cmd_rfsh, 0);
    base = n_ba_ack;
    repeat (100) @(posedge clk);
    #1;
    chk("dl_no_ba_ack", n_ba_ack - base, 0);
    chk("dl_prog_served", n_prog_ack > 0, 1);
    downloading = 0; prog_we = 0;
    push_exp(1);
    wait_ack(1, 80);
    ba1_rd = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("dl_prog_rdy_count", n_prog_rdy, n_prog_ack);

    // ba0 write with ack and done on the same cycle
    ack_dly = 1; done_dly = 1;
    ba0_wr = 1; ba0_rd = 1;
    push_exp(0);
    do_reset();
    wait_cmd(8, n);
    chk("co_cmd_wr", cmd_wr, 1);
    chk("co_cmd_ba", cmd_ba, 0);
    wait_ack(0, 20);
    ba0_wr = 0; ba0_rd = 0; ba2_rd = 1;
    push_exp(2);
    wait_cmd(4, n);
    chk("co_back_to_idle", n, 1);
    wait_ack(2, 20);
    ba2_rd = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("co_ack_rdy_gap", rdy_cyc[0] - ack_cyc[0], 1);

    // Reset in the middle of a command: no ack or rdy for it
    ack_dly = 10; done_dly = 12;
    ba2_rd = 1;
    do_reset();
    wait_cmd(8, n);
    ba2_rd = 0;
    base = n_ba_ack;
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("rst_mid_cmd_req", cmd_req, 0);
    do_reset();
    repeat (20) @(posedge clk);
    #1;
    chk("rst_mid_no_ack", n_ba_ack - base, 0);

    // ba0 and ba3 held together
    ack_dly = 2; done_dly = 4;
`ifdef JTFRAME_SDRAM_FIXPRIO_EN
    fp_seq = '{0, 0, 0, 0};
`else
    fp_seq = '{0, 3, 0, 3};
`endif
    ba0_rd = 1; ba3_rd = 1;
    for (int k = 0; k < 4; k++) push_exp(fp_seq[k]);
    do_reset();
    for (int k = 0; k < 4; k++) wait_ack(fp_seq[k], 60);
    ba0_rd = 0; ba3_rd = 0;
    repeat (12) @(posedge clk);
    #1;

    chk("sb_ack_left", exp_ack.size(), 0);
    chk("sb_rdy_left", exp_rdy.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
